// File: rtl/axi_rd_arbiter_pkg.sv
// axi_rd_arbiter_pkg
//   Shared definitions for the AXI read arbiter slice: default requester IDs,
//   AXI size encodings, requester identifiers and a constant clog2 helper
//   used to size the outstanding-read counters.
package axi_rd_arbiter_pkg;

   localparam logic [3:0] INST_ID_DEFAULT = 4'd0;
   localparam logic [3:0] DATA_ID_DEFAULT = 4'd1;

   localparam logic [2:0] AXI_SIZE_1B = 3'd0;
   localparam logic [2:0] AXI_SIZE_2B = 3'd1;
   localparam logic [2:0] AXI_SIZE_4B = 3'd2;

   typedef enum logic {
      REQ_INST = 1'b0,
      REQ_DATA = 1'b1
   } req_e;

   function automatic int unsigned clog2(input int unsigned value);
      int unsigned r;
      r = 0;
      while ((32'd1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// axi_rd_arbiter_if
//   AXI read-address / read-data channel bundle.
//   master : arbiter side (drives arid/araddr/arsize/arvalid/rready)
//   slave  : memory side  (drives arready/rid/rdata/rvalid)
interface axi_rd_arbiter_if;

   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [2:0]  arsize;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arsize, arvalid, rready,
      input  arready, rid, rdata, rvalid
   );

   modport slave (
      input  arid, araddr, arsize, arvalid, rready,
      output arready, rid, rdata, rvalid
   );

endinterface

// File: rtl/axi_rd_arbiter_ostd_cnt.sv
// axi_rd_ostd_cnt
//   Saturating up/down counter of outstanding reads for one AXI ID.
//   clk, reset : clock, asynchronous active-high reset
//   inc        : a read for this ID was accepted
//   dec        : an R beat for this ID was consumed
//   full       : count has reached MAX_OUTSTANDING
//   empty      : count is zero
module axi_rd_ostd_cnt
   import axi_rd_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic inc,
   input  logic dec,
   output logic full,
   output logic empty
);

   localparam int unsigned W = clog2(MAX_OUTSTANDING + 1);

   logic [W-1:0] cnt;
   logic         do_inc;
   logic         do_dec;

   assign full  = (cnt == W'(MAX_OUTSTANDING));
   assign empty = (cnt == '0);

   // An increment while full is legal only when a decrement retires a slot
   // in the same cycle; a decrement at zero is a stray beat and is ignored.
   always_comb begin
      do_inc = inc && (!full || dec);
      do_dec = dec && !empty;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
      end else if (do_inc && !do_dec) begin
         cnt <= cnt + W'(1);
      end else if (do_dec && !do_inc) begin
         cnt <= cnt - W'(1);
      end
   end

endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter
//   Shares one AXI read channel pair between the instruction-fetch and
//   data-load sram-like requesters. Registers AR, grants one requester per
//   accept, tracks outstanding reads per ID and steers R beats by rid.
//   clk, reset          : clock, asynchronous active-high reset
//   inst_rd_* / data_rd_*: requester ports (req/addr/size in, addr_ok/
//                          data_ok/rdata out)
//   axi                 : AXI AR/R channels (master modport)
//   Build option AXI_RD_ARB_ROUND_ROBIN_EN: alternate grants when both
//   requesters are eligible; otherwise data has fixed priority over inst.
module axi_rd_arbiter
   import axi_rd_arbiter_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [3:0]  INST_ID         = INST_ID_DEFAULT,
   parameter logic [3:0]  DATA_ID         = DATA_ID_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              inst_rd_req,
   input  logic [31:0]       inst_rd_addr,
   input  logic [1:0]        inst_rd_size,
   output logic              inst_rd_addr_ok,
   output logic              inst_rd_data_ok,
   output logic [31:0]       inst_rd_rdata,
   input  logic              data_rd_req,
   input  logic [31:0]       data_rd_addr,
   input  logic [1:0]        data_rd_size,
   output logic              data_rd_addr_ok,
   output logic              data_rd_data_ok,
   output logic [31:0]       data_rd_rdata,
   axi_rd_arbiter_if.master  axi
);

   logic [3:0]  ar_id_q;
   logic [31:0] ar_addr_q;
   logic [2:0]  ar_size_q;
   logic        ar_valid_q;

   logic inst_full, inst_empty, data_full, data_empty;
   logic r_hs, inst_dec, data_dec;
   logic inst_elig, data_elig, slot_free;
   logic grant_inst, grant_data;

   assign axi.arid    = ar_id_q;
   assign axi.araddr  = ar_addr_q;
   assign axi.arsize  = ar_size_q;
   assign axi.arvalid = ar_valid_q;
   assign axi.rready  = !reset;

   assign r_hs     = axi.rvalid && axi.rready;
   assign inst_dec = r_hs && (axi.rid == INST_ID);
   assign data_dec = r_hs && (axi.rid == DATA_ID);

   // A full requester becomes eligible again in the cycle its own R beat
   // retires, so a saturated fetch is accepted alongside that beat.
   assign inst_elig = inst_rd_req && (!inst_full || inst_dec);
   assign data_elig = data_rd_req && (!data_full || data_dec);
   assign slot_free = !ar_valid_q || axi.arready;

   assign inst_rd_addr_ok = grant_inst;
   assign data_rd_addr_ok = grant_data;

`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
   req_e rr_last;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_last <= REQ_INST;
      end else if (grant_data) begin
         rr_last <= REQ_DATA;
      end else if (grant_inst) begin
         rr_last <= REQ_INST;
      end
   end

   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (!reset && slot_free) begin
         if (inst_elig && data_elig) begin
            grant_inst = (rr_last == REQ_DATA);
            grant_data = (rr_last == REQ_INST);
         end else begin
            grant_inst = inst_elig;
            grant_data = data_elig;
         end
      end
   end
`else
   always_comb begin
      grant_inst = 1'b0;
      grant_data = 1'b0;
      if (!reset && slot_free) begin
         grant_data = data_elig;
         grant_inst = inst_elig && !data_elig;
      end
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ar_id_q    <= '0;
         ar_addr_q  <= '0;
         ar_size_q  <= AXI_SIZE_1B;
         ar_valid_q <= 1'b0;
      end else if (grant_data) begin
         ar_id_q    <= DATA_ID;
         ar_addr_q  <= data_rd_addr;
         ar_size_q  <= {1'b0, data_rd_size};
         ar_valid_q <= 1'b1;
      end else if (grant_inst) begin
         ar_id_q    <= INST_ID;
         ar_addr_q  <= inst_rd_addr;
         ar_size_q  <= {1'b0, inst_rd_size};
         ar_valid_q <= 1'b1;
      end else if (axi.arready) begin
         ar_valid_q <= 1'b0;
      end
   end

   // Beats for an ID with nothing outstanding are consumed silently.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inst_rd_data_ok <= 1'b0;
         data_rd_data_ok <= 1'b0;
         inst_rd_rdata   <= '0;
         data_rd_rdata   <= '0;
      end else begin
         inst_rd_data_ok <= inst_dec && !inst_empty;
         data_rd_data_ok <= data_dec && !data_empty;
         if (inst_dec && !inst_empty) inst_rd_rdata <= axi.rdata;
         if (data_dec && !data_empty) data_rd_rdata <= axi.rdata;
      end
   end

   axi_rd_ostd_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_inst_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (grant_inst),
      .dec   (inst_dec),
      .full  (inst_full),
      .empty (inst_empty)
   );

   axi_rd_ostd_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_data_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (grant_data),
      .dec   (data_dec),
      .full  (data_full),
      .empty (data_empty)
   );

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter
//   Scoreboard bench for axi_rd_arbiter: expected AR beats and read data are
//   queued when stimulus is driven and compared when the DUT produces them.
//   Build option AXI_RD_ARB_ROUND_ROBIN_EN selects the alternating-grant
//   expectations in the burst scenario.
module tb_axi_rd_arbiter;

   typedef struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [2:0]  size;
   } ar_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_rd_req, data_rd_req;
   logic [31:0] inst_rd_addr, data_rd_addr;
   logic [1:0]  inst_rd_size, data_rd_size;
   logic        inst_rd_addr_ok, data_rd_addr_ok;
   logic        inst_rd_data_ok, data_rd_data_ok;
   logic [31:0] inst_rd_rdata, data_rd_rdata;

   axi_rd_arbiter_if bus();

   axi_rd_arbiter #(
      .MAX_OUTSTANDING (2),
      .INST_ID         (4'd0),
      .DATA_ID         (4'd1)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .inst_rd_req     (inst_rd_req),
      .inst_rd_addr    (inst_rd_addr),
      .inst_rd_size    (inst_rd_size),
      .inst_rd_addr_ok (inst_rd_addr_ok),
      .inst_rd_data_ok (inst_rd_data_ok),
      .inst_rd_rdata   (inst_rd_rdata),
      .data_rd_req     (data_rd_req),
      .data_rd_addr    (data_rd_addr),
      .data_rd_size    (data_rd_size),
      .data_rd_addr_ok (data_rd_addr_ok),
      .data_rd_data_ok (data_rd_data_ok),
      .data_rd_rdata   (data_rd_rdata),
      .axi             (bus)
   );

   always #5 clk = ~clk;

   int unsigned n_total = 0;
   int unsigned n_bad   = 0;

   ar_t         ar_q[$];
   logic [31:0] inst_q[$];
   logic [31:0] data_q[$];
   ar_t         mon_ar;
   logic [31:0] mon_d;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic push_ar(input logic [3:0] id, input logic [31:0] addr, input logic [2:0] size);
      ar_t e;
      e.id = id; e.addr = addr; e.size = size;
      ar_q.push_back(e);
   endtask

   // who: 0 = no response expected, 1 = fetch side, 2 = load side
   task automatic rbeat(input logic [3:0] id, input logic [31:0] d, input int who);
      bus.rvalid = 1'b1;
      bus.rid    = id;
      bus.rdata  = d;
      if (who == 1) inst_q.push_back(d);
      if (who == 2) data_q.push_back(d);
      cyc();
      bus.rvalid = 1'b0;
   endtask

   // Scoreboard side: compare every AR handshake and every data_ok pulse.
   always @(negedge clk) begin
      if (!reset) begin
         if (bus.arvalid && bus.arready) begin
            if (ar_q.size() == 0) begin
               check("ar_queue_nonempty", 64'(ar_q.size()), 64'd1);
            end else begin
               mon_ar = ar_q.pop_front();
               check("arid", 64'(bus.arid), 64'(mon_ar.id));
               check("araddr", 64'(bus.araddr), 64'(mon_ar.addr));
               check("arsize", 64'(bus.arsize), 64'(mon_ar.size));
            end
         end
         if (inst_rd_data_ok) begin
            if (inst_q.size() == 0) begin
               check("inst_q_nonempty", 64'(inst_q.size()), 64'd1);
            end else begin
               mon_d = inst_q.pop_front();
               check("inst_rdata", 64'(inst_rd_rdata), 64'(mon_d));
            end
         end
         if (data_rd_data_ok) begin
            if (data_q.size() == 0) begin
               check("data_q_nonempty", 64'(data_q.size()), 64'd1);
            end else begin
               mon_d = data_q.pop_front();
               check("data_rdata", 64'(data_rd_rdata), 64'(mon_d));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   logic [3:0] burst_id [3];

   initial begin
`ifdef AXI_RD_ARB_ROUND_ROBIN_EN
      burst_id[0] = 4'd1; burst_id[1] = 4'd0; burst_id[2] = 4'd1;
`else
      burst_id[0] = 4'd1; burst_id[1] = 4'd1; burst_id[2] = 4'd0;
`endif
      reset = 1'b1;
      inst_rd_req = 1'b1; inst_rd_addr = 32'h40; inst_rd_size = 2'd2;
      data_rd_req = 1'b0; data_rd_addr = '0;     data_rd_size = 2'd0;
      bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0;

      // Reset values, with a request pending that must not be accepted
      repeat (2) at_neg();
      check("rst_arvalid", 64'(bus.arvalid), 64'd0);
      check("rst_rready", 64'(bus.rready), 64'd0);
      check("rst_arid", 64'(bus.arid), 64'd0);
      check("rst_araddr", 64'(bus.araddr), 64'd0);
      check("rst_arsize", 64'(bus.arsize), 64'd0);
      check("rst_inst_addr_ok", 64'(inst_rd_addr_ok), 64'd0);
      check("rst_data_addr_ok", 64'(data_rd_addr_ok), 64'd0);
      check("rst_inst_data_ok", 64'(inst_rd_data_ok), 64'd0);
      check("rst_data_data_ok", 64'(data_rd_data_ok), 64'd0);
      check("rst_inst_rdata", 64'(inst_rd_rdata), 64'd0);
      check("rst_data_rdata", 64'(data_rd_rdata), 64'd0);
      inst_rd_req = 1'b0;
      cyc();
      reset = 1'b0;
      at_neg();
      check("rready_after_rst", 64'(bus.rready), 64'd1);

      // Single fetch
      cyc();
      inst_rd_req = 1'b1; inst_rd_addr = 32'h1C00_0000; inst_rd_size = 2'd2;
      bus.arready = 1'b1;
      push_ar(4'd0, 32'h1C00_0000, 3'd2);
      at_neg();
      check("t1_inst_addr_ok", 64'(inst_rd_addr_ok), 64'd1);
      check("t1_data_addr_ok", 64'(data_rd_addr_ok), 64'd0);
      cyc();
      inst_rd_req = 1'b0;
      at_neg();
      check("t1_arvalid", 64'(bus.arvalid), 64'd1);
      cyc();
      rbeat(4'd0, 32'h0280_0000, 1);
      at_neg();
      check("t1_inst_data_ok", 64'(inst_rd_data_ok), 64'd1);
      check("t1_inst_rdata", 64'(inst_rd_rdata), 64'h0280_0000);

      // Collision: data wins, inst follows next cycle
      cyc();
      inst_rd_req = 1'b1; inst_rd_addr = 32'h100; inst_rd_size = 2'd2;
      data_rd_req = 1'b1; data_rd_addr = 32'h200; data_rd_size = 2'd2;
      push_ar(4'd1, 32'h200, 3'd2);
      push_ar(4'd0, 32'h100, 3'd2);
      at_neg();
      check("t2_data_addr_ok", 64'(data_rd_addr_ok), 64'd1);
      check("t2_inst_addr_ok", 64'(inst_rd_addr_ok), 64'd0);
      cyc();
      data_rd_req = 1'b0;
      at_neg();
      check("t2_inst_addr_ok2", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      inst_rd_req = 1'b0;
      rbeat(4'd1, 32'hAAAA_0002, 2);
      rbeat(4'd0, 32'hAAAA_0001, 1);
      cyc();

      // AR stall
      bus.arready = 1'b0;
      data_rd_req = 1'b1; data_rd_addr = 32'h300; data_rd_size = 2'd1;
      push_ar(4'd1, 32'h300, 3'd1);
      at_neg();
      check("t3_data_addr_ok", 64'(data_rd_addr_ok), 64'd1);
      cyc();
      data_rd_req = 1'b0;
      inst_rd_req = 1'b1; inst_rd_addr = 32'h400; inst_rd_size = 2'd0;
      for (int i = 0; i < 3; i++) begin
         at_neg();
         check("stall_inst_addr_ok", 64'(inst_rd_addr_ok), 64'd0);
         check("stall_arvalid", 64'(bus.arvalid), 64'd1);
         check("stall_arid", 64'(bus.arid), 64'd1);
         check("stall_araddr", 64'(bus.araddr), 64'h300);
         check("stall_arsize", 64'(bus.arsize), 64'd1);
         cyc();
      end
      bus.arready = 1'b1;
      push_ar(4'd0, 32'h400, 3'd0);
      at_neg();
      check("t3_grant_on_ready", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      inst_rd_req = 1'b0;
      at_neg();
      cyc();
      rbeat(4'd1, 32'hBBBB_0001, 2);
      rbeat(4'd0, 32'hBBBB_0002, 1);
      cyc();

      // Saturation of the fetch side
      inst_rd_req = 1'b1; inst_rd_addr = 32'h500; inst_rd_size = 2'd2;
      push_ar(4'd0, 32'h500, 3'd2);
      at_neg();
      check("sat_acc1", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      push_ar(4'd0, 32'h500, 3'd2);
      at_neg();
      check("sat_acc2", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      data_rd_req = 1'b1; data_rd_addr = 32'h600; data_rd_size = 2'd2;
      push_ar(4'd1, 32'h600, 3'd2);
      at_neg();
      check("sat_inst_blocked", 64'(inst_rd_addr_ok), 64'd0);
      check("sat_data_granted", 64'(data_rd_addr_ok), 64'd1);
      cyc();
      data_rd_req = 1'b0;
      at_neg();
      check("sat_inst_blocked2", 64'(inst_rd_addr_ok), 64'd0);
      cyc();
      bus.rvalid = 1'b1; bus.rid = 4'd0; bus.rdata = 32'hCCCC_0001;
      inst_q.push_back(32'hCCCC_0001);
      push_ar(4'd0, 32'h500, 3'd2);
      at_neg();
      check("sat_acc_with_r", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      bus.rvalid = 1'b0;
      inst_rd_req = 1'b0;
      rbeat(4'd0, 32'hCCCC_0002, 1);
      rbeat(4'd0, 32'hCCCC_0003, 1);
      rbeat(4'd1, 32'hCCCC_0004, 2);
      cyc();

      // Out-of-order R, unknown ID, stray beat for an idle ID
      inst_rd_req = 1'b1; inst_rd_addr = 32'h700; inst_rd_size = 2'd2;
      push_ar(4'd0, 32'h700, 3'd2);
      at_neg();
      check("ooo_inst_acc", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      inst_rd_req = 1'b0;
      data_rd_req = 1'b1; data_rd_addr = 32'h800; data_rd_size = 2'd1;
      push_ar(4'd1, 32'h800, 3'd1);
      at_neg();
      check("ooo_data_acc", 64'(data_rd_addr_ok), 64'd1);
      cyc();
      data_rd_req = 1'b0;
      rbeat(4'd1, 32'hD0D0_D0D0, 2);
      at_neg();
      check("ooo_data_first", 64'(data_rd_data_ok), 64'd1);
      check("ooo_inst_not_yet", 64'(inst_rd_data_ok), 64'd0);
      cyc();
      rbeat(4'd0, 32'h1111_2222, 1);
      at_neg();
      check("ooo_inst_second", 64'(inst_rd_data_ok), 64'd1);
      cyc();
      rbeat(4'd5, 32'h0BAD_0005, 0);
      at_neg();
      check("rid5_inst_ok", 64'(inst_rd_data_ok), 64'd0);
      check("rid5_data_ok", 64'(data_rd_data_ok), 64'd0);
      cyc();
      rbeat(4'd0, 32'h0BAD_0000, 0);
      at_neg();
      check("idle_id_data_ok", 64'(inst_rd_data_ok), 64'd0);
      cyc();
      // Counter must still be exactly zero: two accepts then saturation
      inst_rd_req = 1'b1; inst_rd_addr = 32'h900; inst_rd_size = 2'd2;
      push_ar(4'd0, 32'h900, 3'd2);
      at_neg();
      check("held0_acc1", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      push_ar(4'd0, 32'h900, 3'd2);
      at_neg();
      check("held0_acc2", 64'(inst_rd_addr_ok), 64'd1);
      cyc();
      at_neg();
      check("held0_full", 64'(inst_rd_addr_ok), 64'd0);
      cyc();
      inst_rd_req = 1'b0;
      rbeat(4'd0, 32'hEEEE_0001, 1);
      rbeat(4'd0, 32'hEEEE_0002, 1);
      cyc();

      // Both requesting continuously, then asynchronous reset mid-burst
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      inst_rd_req = 1'b1; inst_rd_addr = 32'h100; inst_rd_size = 2'd2;
      data_rd_req = 1'b1; data_rd_addr = 32'h200; data_rd_size = 2'd2;
      for (int k = 0; k < 3; k++) begin
         push_ar(burst_id[k], (burst_id[k] == 4'd1) ? 32'h200 : 32'h100, 3'd2);
         at_neg();
         check("burst_data_ok", 64'(data_rd_addr_ok), 64'(burst_id[k] == 4'd1));
         check("burst_inst_ok", 64'(inst_rd_addr_ok), 64'(burst_id[k] == 4'd0));
         cyc();
      end
      #1;
      check("pre_rst_arvalid", 64'(bus.arvalid), 64'd1);
      #1;
      reset = 1'b1;
      #1;
      check("async_rst_arvalid", 64'(bus.arvalid), 64'd0);
      check("async_rst_rready", 64'(bus.rready), 64'd0);
      ar_q.delete();
      inst_rd_req = 1'b0;
      data_rd_req = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      at_neg();
      check("post_rst_arvalid", 64'(bus.arvalid), 64'd0);
      cyc();
      // Load counter was at its limit before reset; it must be cleared now
      data_rd_req = 1'b1; data_rd_addr = 32'hA00; data_rd_size = 2'd2;
      push_ar(4'd1, 32'hA00, 3'd2);
      at_neg();
      check("post_rst_data_acc", 64'(data_rd_addr_ok), 64'd1);
      cyc();
      data_rd_req = 1'b0;
      at_neg();
      cyc();
      rbeat(4'd1, 32'hF00D_0001, 2);
      cyc();
      cyc();

      check("ar_q_drained", 64'(ar_q.size()), 64'd0);
      check("inst_q_drained", 64'(inst_q.size()), 64'd0);
      check("data_q_drained", 64'(data_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
